mem_port_arbiter: RTL and testbench

- Shares the single memory port of the rv32 1-port Sodor configuration between instruction fetch (imem) and load/store (dmem).
- Sits between the core datapath's imem/dmem request/response interfaces and the single-ported memory.
- Allows at most one transaction in flight. Data access has priority over fetch, and a streak limit prevents fetch starvation.
- A response watchdog recovers the port if the memory never answers.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (imem) and load/store (dmem).
// One transaction in flight; dmem has priority, bounded by a streak limit; a watchdog aborts lost responses.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_imem_req_valid,
    output logic              io_imem_req_ready,
    input  logic [ADDR_W-1:0] io_imem_req_addr,
    output logic              io_imem_resp_valid,
    output logic [DATA_W-1:0] io_imem_resp_data,
    input  logic              io_dmem_req_valid,
    output logic              io_dmem_req_ready,
    input  logic [ADDR_W-1:0] io_dmem_req_addr,
    input  logic [DATA_W-1:0] io_dmem_req_data,
    input  logic              io_dmem_req_fcn,
    input  logic [2:0]        io_dmem_req_typ,
    output logic              io_dmem_resp_valid,
    output logic [DATA_W-1:0] io_dmem_resp_data,
    output logic              io_mem_req_valid,
    input  logic              io_mem_req_ready,
    output logic [ADDR_W-1:0] io_mem_req_addr,
    output logic [DATA_W-1:0] io_mem_req_data,
    output logic              io_mem_req_fcn,
    output logic [2:0]        io_mem_req_typ,
    input  logic              io_mem_resp_valid,
    input  logic [DATA_W-1:0] io_mem_resp_data,
    output logic              io_busy,
    output logic              io_timeout
);
    localparam int ST_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [0:0]      S_IDLE     = 1'b0;
    localparam logic [0:0]      S_BUSY     = 1'b1;
    localparam logic [ST_W-1:0] STREAK_MAX = ST_W'(MAX_DATA_STREAK);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

    logic [0:0]      state;
    logic            owner;
    logic [ST_W-1:0] streak;
    logic [WD_W-1:0] wdog;
    logic            timeout_q;
    logic            idle;
    logic            gnt_d;
    logic            gnt_i;
    logic            fire;
    logic            resp_hit;
    logic            wd_expire;

    // Valid/ready handshake: a request transfers on any cycle where io_mem_req_valid and
    // io_mem_req_ready are both high; requesters see ready only on that same cycle, and may
    // withdraw valid at any time before it.
    assign idle  = (state == S_IDLE) && reset;
    assign gnt_d = idle && io_dmem_req_valid && !(io_imem_req_valid && (streak == STREAK_MAX));
    assign gnt_i = idle && io_imem_req_valid && !gnt_d;

    assign io_mem_req_valid  = gnt_d | gnt_i;
    assign io_mem_req_addr   = gnt_i ? io_imem_req_addr : io_dmem_req_addr;
    assign io_mem_req_data   = gnt_i ? '0 : io_dmem_req_data;
    assign io_mem_req_fcn    = gnt_i ? 1'b0 : io_dmem_req_fcn;
    assign io_mem_req_typ    = gnt_i ? 3'b011 : io_dmem_req_typ;
    assign io_imem_req_ready = gnt_i && io_mem_req_ready;
    assign io_dmem_req_ready = gnt_d && io_mem_req_ready;
    assign fire              = io_mem_req_valid && io_mem_req_ready;

    assign io_busy            = (state == S_BUSY);
    assign resp_hit           = io_busy && io_mem_resp_valid;
    assign io_imem_resp_valid = resp_hit && !owner;
    assign io_dmem_resp_valid = resp_hit && owner;
    assign io_imem_resp_data  = io_mem_resp_data;
    assign io_dmem_resp_data  = io_mem_resp_data;
    assign io_timeout         = timeout_q;

    // A response arriving in the same cycle as expiry is delivered, not aborted.
    assign wd_expire = io_busy && !io_mem_resp_valid && (wdog == WD_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            streak    <= '0;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        state <= S_BUSY;
                        owner <= gnt_d;
                        wdog  <= '0;
                        // Streak only grows while fetch is actually waiting behind data.
                        if (gnt_d && io_imem_req_valid)
                            streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                        else
                            streak <= '0;
                    end
                end
                S_BUSY: begin
                    if (io_mem_resp_valid) begin
                        state <= S_IDLE;
                    end else if (wd_expire) begin
                        state     <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset checks, vector table, directed multi-cycle sequences
// and a randomized run against a transaction-level model of the port sharing rules.
module tb_mem_port_arbiter;
    localparam int MAX_STREAK = 4;
    localparam int TO_CYC     = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_imem_req_valid, io_imem_req_ready;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_dmem_req_valid, io_dmem_req_ready;
    logic [31:0] io_dmem_req_addr, io_dmem_req_data;
    logic        io_dmem_req_fcn;
    logic [2:0]  io_dmem_req_typ;
    logic        io_dmem_resp_valid;
    logic [31:0] io_dmem_resp_data;
    logic        io_mem_req_valid, io_mem_req_ready;
    logic [31:0] io_mem_req_addr, io_mem_req_data;
    logic        io_mem_req_fcn;
    logic [2:0]  io_mem_req_typ;
    logic        io_mem_resp_valid;
    logic [31:0] io_mem_resp_data;
    logic        io_busy, io_timeout;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAX_STREAK), .TIMEOUT(TO_CYC)) dut (
        .clock(clock), .reset(reset),
        .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
        .io_imem_req_addr(io_imem_req_addr), .io_imem_resp_valid(io_imem_resp_valid),
        .io_imem_resp_data(io_imem_resp_data),
        .io_dmem_req_valid(io_dmem_req_valid), .io_dmem_req_ready(io_dmem_req_ready),
        .io_dmem_req_addr(io_dmem_req_addr), .io_dmem_req_data(io_dmem_req_data),
        .io_dmem_req_fcn(io_dmem_req_fcn), .io_dmem_req_typ(io_dmem_req_typ),
        .io_dmem_resp_valid(io_dmem_resp_valid), .io_dmem_resp_data(io_dmem_resp_data),
        .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
        .io_mem_req_addr(io_mem_req_addr), .io_mem_req_data(io_mem_req_data),
        .io_mem_req_fcn(io_mem_req_fcn), .io_mem_req_typ(io_mem_req_typ),
        .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_data(io_mem_resp_data),
        .io_busy(io_busy), .io_timeout(io_timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        iv;
        logic        dv;
        logic        mr;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] ddata;
        logic        dfcn;
        logic [2:0]  dtyp;
        logic        e_valid;
        logic        e_irdy;
        logic        e_drdy;
        logic [31:0] e_addr;
        logic        e_fcn;
        logic [2:0]  e_typ;
        logic        chk_data;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        io_imem_req_valid = 1'b0; io_imem_req_addr = 32'h0;
        io_dmem_req_valid = 1'b0; io_dmem_req_addr = 32'h0; io_dmem_req_data = 32'h0;
        io_dmem_req_fcn = 1'b0; io_dmem_req_typ = 3'b000;
        io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0; io_mem_resp_data = 32'h0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Transaction-level model state
    bit m_busy, m_owner, m_to;
    int m_streak, m_age;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h200, 32'h44, 32'h0, 1'b0, 3'b010,
                    1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 3'b011, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h200, 32'h1000, 32'hDEADBEEF, 1'b1, 3'b010,
                    1'b1, 1'b0, 1'b1, 32'h1000, 1'b1, 3'b010, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h204, 32'h2000, 32'h12345678, 1'b0, 3'b001,
                    1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 3'b001, 1'b1, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h208, 32'h3000, 32'hCAFE0000, 1'b1, 3'b000,
                    1'b1, 1'b0, 1'b0, 32'h3000, 1'b1, 3'b000, 1'b1, 32'hCAFE0000};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h20C, 32'h4000, 32'h55AA55AA, 1'b1, 3'b100,
                    1'b0, 1'b0, 1'b0, 32'h4000, 1'b1, 3'b100, 1'b1, 32'h55AA55AA};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h210, 32'h5000, 32'h0, 1'b1, 3'b010,
                    1'b1, 1'b0, 1'b0, 32'h210, 1'b0, 3'b011, 1'b0, 32'h0};

        // Outputs held quiet while reset is asserted, even with every request active
        idle_inputs();
        io_imem_req_valid = 1'b1; io_dmem_req_valid = 1'b1; io_mem_req_ready = 1'b1;
        io_mem_resp_valid = 1'b1;
        #3;
        chk("rst_mem_req_valid", io_mem_req_valid, 0);
        chk("rst_readys", {io_imem_req_ready, io_dmem_req_ready}, 0);
        chk("rst_resp_valids", {io_imem_resp_valid, io_dmem_resp_valid}, 0);
        chk("rst_busy_timeout", {io_busy, io_timeout}, 0);

        // Vector table: grant and field muxing from a fresh IDLE state
        for (int i = 0; i < 6; i++) begin
            do_reset();
            io_imem_req_valid = vecs[i].iv; io_dmem_req_valid = vecs[i].dv;
            io_mem_req_ready = vecs[i].mr; io_imem_req_addr = vecs[i].iaddr;
            io_dmem_req_addr = vecs[i].daddr; io_dmem_req_data = vecs[i].ddata;
            io_dmem_req_fcn = vecs[i].dfcn; io_dmem_req_typ = vecs[i].dtyp;
            settle();
            chk($sformatf("vec%0d_valid", i), io_mem_req_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_readys", i), {io_imem_req_ready, io_dmem_req_ready},
                {vecs[i].e_irdy, vecs[i].e_drdy});
            chk($sformatf("vec%0d_addr", i), io_mem_req_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_fcn_typ", i), {io_mem_req_fcn, io_mem_req_typ},
                {vecs[i].e_fcn, vecs[i].e_typ});
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), io_mem_req_data, vecs[i].e_data);
        end

        // Fetch only: grant at cycle 0, response at cycle 3
        do_reset();
        io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h200; io_mem_req_ready = 1'b1;
        settle();
        chk("fetch_c0_iready", io_imem_req_ready, 1);
        chk("fetch_c0_fields", {io_mem_req_addr, io_mem_req_fcn, io_mem_req_typ}, {32'h200, 1'b0, 3'b011});
        step();
        io_imem_req_valid = 1'b0;
        settle();
        chk("fetch_c1_busy", io_busy, 1);
        step();
        settle();
        chk("fetch_c2_no_resp", {io_busy, io_imem_resp_valid}, 2'b10);
        step();
        io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h00000013;
        settle();
        chk("fetch_c3_resp", {io_imem_resp_valid, io_dmem_resp_valid}, 2'b10);
        chk("fetch_c3_data", io_imem_resp_data, 32'h13);
        step();
        io_mem_resp_valid = 1'b0;
        settle();
        chk("fetch_c4_idle", io_busy, 0);

        // Conflict: store wins, fetch follows on next IDLE cycle
        do_reset();
        io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h200;
        io_dmem_req_valid = 1'b1; io_dmem_req_addr = 32'h1000; io_dmem_req_data = 32'hDEADBEEF;
        io_dmem_req_fcn = 1'b1; io_dmem_req_typ = 3'b010; io_mem_req_ready = 1'b1;
        settle();
        chk("conf_readys", {io_imem_req_ready, io_dmem_req_ready}, 2'b01);
        chk("conf_fields", {io_mem_req_fcn, io_mem_req_addr, io_mem_req_data}, {1'b1, 32'h1000, 32'hDEADBEEF});
        step();
        io_dmem_req_valid = 1'b0;
        settle();
        chk("conf_busy_blocks", {io_busy, io_mem_req_valid, io_imem_req_ready}, 3'b100);
        io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h0;
        #1;
        chk("conf_resp_route", {io_imem_resp_valid, io_dmem_resp_valid}, 2'b01);
        step();
        io_mem_resp_valid = 1'b0;
        settle();
        chk("conf_fetch_next", {io_imem_req_ready, io_mem_req_addr}, {1'b1, 32'h200});

        // Starvation: sustained conflict yields four data grants then one fetch
        do_reset();
        io_imem_req_valid = 1'b1; io_dmem_req_valid = 1'b1; io_mem_req_ready = 1'b1;
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        got_q = {};
        for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
            settle();
            if (io_mem_req_valid && io_mem_req_ready) got_q.push_back(io_dmem_req_ready);
            io_mem_resp_valid = io_busy;
            step();
            io_mem_resp_valid = 1'b0;
        end
        chk("starve_grant_count", got_q.size(), 6);
        for (int k = 0; k < 6 && got_q.size() > 0; k++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            chk($sformatf("starve_grant%0d_is_dmem", k), got_q.pop_front(), e);
        end

        // Backpressure: no grant while memory is not ready
        do_reset();
        io_dmem_req_valid = 1'b1; io_dmem_req_addr = 32'h80;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("bp%0d_stall", c), {io_mem_req_valid, io_dmem_req_ready, io_busy}, 3'b100);
            step();
        end
        io_mem_req_ready = 1'b1;
        settle();
        chk("bp_grant", io_dmem_req_ready, 1);
        step();
        io_dmem_req_valid = 1'b0;
        settle();
        chk("bp_busy", io_busy, 1);

        // Watchdog: abort after TO_CYC silent BUSY cycles, one-cycle pulse, late response dropped
        do_reset();
        io_imem_req_valid = 1'b1; io_mem_req_ready = 1'b1;
        settle();
        chk("wd_grant", io_imem_req_ready, 1);
        step();
        io_imem_req_valid = 1'b0;
        begin
            int n;
            n = 0;
            settle();
            while (io_busy && n < 20) begin
                if (io_timeout) chk("wd_early_pulse", io_timeout, 0);
                n++;
                step();
                settle();
            end
            chk("wd_busy_cycles", n, TO_CYC);
        end
        chk("wd_pulse_high", io_timeout, 1);
        step();
        settle();
        chk("wd_pulse_low", io_timeout, 0);
        io_mem_resp_valid = 1'b1;
        #1;
        chk("wd_late_resp_dropped", {io_imem_resp_valid, io_dmem_resp_valid}, 2'b00);
        step();
        io_mem_resp_valid = 1'b0;
        settle();
        chk("wd_late_stays_idle", {io_busy, io_timeout}, 2'b00);

        // Response on the final watchdog cycle wins
        do_reset();
        io_dmem_req_valid = 1'b1; io_mem_req_ready = 1'b1;
        step();
        io_dmem_req_valid = 1'b0;
        repeat (TO_CYC - 1) step();
        io_mem_resp_valid = 1'b1;
        settle();
        chk("wd_tie_resp", {io_busy, io_dmem_resp_valid}, 2'b11);
        step();
        io_mem_resp_valid = 1'b0;
        settle();
        chk("wd_tie_no_pulse", {io_busy, io_timeout}, 2'b00);

        // Reset mid-BUSY with streak at its limit: after release data wins again
        do_reset();
        io_imem_req_valid = 1'b1; io_dmem_req_valid = 1'b1; io_mem_req_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            if (g < 3) begin
                io_mem_resp_valid = 1'b1;
                step();
                io_mem_resp_valid = 1'b0;
            end
        end
        #2 reset = 1'b0;
        #1;
        chk("rstmid_busy_drop", {io_busy, io_mem_req_valid}, 2'b00);
        @(posedge clock);
        #1 reset = 1'b1;
        settle();
        chk("rstmid_dmem_first", {io_imem_req_ready, io_dmem_req_ready}, 2'b01);

        // Randomized run against the model
        do_reset();
        m_busy = 0; m_owner = 0; m_to = 0; m_streak = 0; m_age = 0;
        for (int c = 0; c < 3000; c++) begin
            bit want_d, want_i, fire;
            io_imem_req_valid = ($urandom_range(0, 9) < 7);
            io_dmem_req_valid = ($urandom_range(0, 9) < 7);
            io_imem_req_addr = $urandom; io_dmem_req_addr = $urandom;
            io_dmem_req_data = $urandom; io_dmem_req_fcn = 1'($urandom_range(0, 1));
            io_dmem_req_typ = 3'($urandom_range(0, 7));
            io_mem_req_ready = ($urandom_range(0, 3) != 0);
            io_mem_resp_valid = m_busy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
            io_mem_resp_data = $urandom;
            settle();
            want_d = !m_busy && io_dmem_req_valid && !(io_imem_req_valid && m_streak >= MAX_STREAK);
            want_i = !m_busy && io_imem_req_valid && !want_d;
            fire = (want_d || want_i) && io_mem_req_ready;
            chk("rnd_ctrl",
                {io_mem_req_valid, io_imem_req_ready, io_dmem_req_ready,
                 io_imem_resp_valid, io_dmem_resp_valid, io_busy, io_timeout},
                {want_d | want_i, want_i & io_mem_req_ready, want_d & io_mem_req_ready,
                 m_busy & io_mem_resp_valid & !m_owner, m_busy & io_mem_resp_valid & m_owner,
                 m_busy, m_to});
            if (want_d || want_i)
                chk("rnd_addr", io_mem_req_addr, want_i ? io_imem_req_addr : io_dmem_req_addr);
            chk("rnd_resp_data", {io_imem_resp_data, io_dmem_resp_data}, {io_mem_resp_data, io_mem_resp_data});
            m_to = 0;
            if (fire) begin
                m_busy = 1; m_owner = want_d; m_age = 0;
                if (want_d && io_imem_req_valid) m_streak = (m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1;
                else m_streak = 0;
            end else if (m_busy) begin
                if (io_mem_resp_valid) m_busy = 0;
                else begin
                    m_age++;
                    if (m_age == TO_CYC) begin
                        m_busy = 0;
                        m_to = 1;
                    end
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
